// File: rtl/tt_8_5_pkg.sv
// Shared constants and the 256-row truth table of F(x) = x[7:4] + x[3:0].
// The table is built at elaboration time and only drives minterm/maxterm selection.
package tt_8_5_pkg;

  localparam int N_IN  = 8;
  localparam int N_OUT = 5;
  localparam int N_ROWS = 1 << N_IN;

  typedef logic [N_ROWS-1:0][N_OUT-1:0] tt_t;

  function automatic tt_t tt_build();
    tt_t        t;
    logic [7:0] xv;
    t = '0;
    for (int x = 0; x < N_ROWS; x++) begin
      xv    = 8'(x);
      t[xv] = {1'b0, xv[7:4]} + {1'b0, xv[3:0]};
    end
    return t;
  endfunction

  localparam tt_t TT = tt_build();

endpackage

// File: rtl/tt_8_5_forms.sv
// Purely combinational canonical DNF and CNF realisations of the truth table.
// Each term is a full 8-literal equality/inequality against one row index.
module tt_8_5_forms
  import tt_8_5_pkg::*;
(
  input  logic [N_IN-1:0]  x_i,
  output logic [N_OUT-1:0] y_dnf_o,
  output logic [N_OUT-1:0] y_cnf_o
);

  logic [N_OUT-1:0][N_ROWS-1:0] dnf_terms;
  logic [N_OUT-1:0][N_ROWS-1:0] cnf_terms;

  for (genvar j = 0; j < N_OUT; j++) begin : g_bit
    for (genvar v = 0; v < N_ROWS; v++) begin : g_row
      // Rows where the bit is 1 contribute a minterm; rows where it is 0 a maxterm.
      if (TT[v][j]) begin : g_one
        assign dnf_terms[j][v] = (x_i == 8'(v));
        assign cnf_terms[j][v] = 1'b1;
      end else begin : g_zero
        assign dnf_terms[j][v] = 1'b0;
        assign cnf_terms[j][v] = (x_i != 8'(v));
      end
    end
    assign y_dnf_o[j] = |dnf_terms[j];
    assign y_cnf_o[j] = &cnf_terms[j];
  end

endmodule

// File: rtl/truth_table_8_5.sv
// Registered evaluator of F(x) = x[7:4] + x[3:0] via both canonical forms,
// with a per-cycle (non-sticky) disagreement flag.
module truth_table_8_5
  import tt_8_5_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  i_x,
  output logic [N_OUT-1:0] o_y_dnf,
  output logic [N_OUT-1:0] o_y_cnf,
  output logic             o_error
);

  logic [N_OUT-1:0] y_dnf_d, y_dnf_q;
  logic [N_OUT-1:0] y_cnf_d, y_cnf_q;
  logic             error_d, error_q;

  tt_8_5_forms u_forms (
    .x_i     (i_x),
    .y_dnf_o (y_dnf_d),
    .y_cnf_o (y_cnf_d)
  );

  assign error_d = (y_dnf_d != y_cnf_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_dnf_q <= '0;
      y_cnf_q <= '0;
      error_q <= 1'b0;
    end else begin
      y_dnf_q <= y_dnf_d;
      y_cnf_q <= y_cnf_d;
      error_q <= error_d;
    end
  end

  assign o_y_dnf = y_dnf_q;
  assign o_y_cnf = y_cnf_q;
  assign o_error = error_q;

endmodule

// File: tb/tb_truth_table_8_5.sv
// Bench for truth_table_8_5: arithmetic reference model feeding an expected queue,
// drained one entry per rising edge while out of reset.
module tb_truth_table_8_5;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_x;
  logic [4:0] o_y_dnf;
  logic [4:0] o_y_cnf;
  logic       o_error;

  logic [4:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  truth_table_8_5 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_x     (i_x),
    .o_y_dnf (o_y_dnf),
    .o_y_cnf (o_y_cnf),
    .o_error (o_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model_f(input logic [7:0] x);
    logic [4:0] hi, lo;
    hi = {1'b0, x[7:4]};
    lo = {1'b0, x[3:0]};
    return hi + lo;
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_dnf"}, {3'b0, o_y_dnf}, 8'd0);
    check_eq({tag, "_cnf"}, {3'b0, o_y_cnf}, 8'd0);
    check_eq({tag, "_err"}, {7'b0, o_error}, 8'd0);
  endtask

  // driver
  task automatic drive(input logic [7:0] x);
    @(negedge clk);
    i_x = x;
    exp_q.push_back(model_f(x));
  endtask

  // scoreboard: one expected entry retires per rising edge
  always @(posedge clk) begin
    logic [4:0] e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("dnf", {3'b0, o_y_dnf}, {3'b0, e});
      check_eq("cnf", {3'b0, o_y_cnf}, {3'b0, e});
      check_eq("err", {7'b0, o_error}, 8'd0);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    i_x      = 8'hFF;

    // reset held with clock running and all-ones input
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_hold");
      @(posedge clk);
      #2;
      check_zero("reset_post_edge");
    end

    // release: the first sample (8'hFF) is taken on the next rising edge
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model_f(8'hFF));

    // directed vectors, back-to-back
    drive(8'h00);
    drive(8'hFF);
    drive(8'h0F);
    drive(8'h81);
    drive(8'h12);

    // random burst
    repeat (20) drive(8'($urandom_range(0, 255)));

    // exhaustive sweep with a reset pulse at 8'h80
    for (int v = 0; v < 256; v++) begin
      drive(8'(v));
      if (v == 8'h80) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_clear");
        exp_q.delete();
        @(posedge clk);
        #2;
        check_zero("reset_pulse_edge");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model_f(8'h80));
      end
    end

    // bounded drain
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check_eq("drain", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_8_5.md
Name: truth_table_8_5

Overview:
- Registered evaluator of one fixed 8-input, 5-output Boolean function (truth table of 256 rows).
- The function is computed two independent ways:
  - canonical disjunctive normal form (DNF: OR of minterms);
  - canonical conjunctive normal form (CNF: AND of maxterms).
- Both results are registered, and a mismatch flag is raised if they ever disagree.
- Serves as the reference/self-checking logic block for truth-table-derived combinational functions in the datapath.

Parameters:
- N_IN, 8, number of function inputs (fixed; not overridable).
- N_OUT, 5, number of function outputs (fixed; not overridable).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- i_x  input  8  function argument; i_x[0] is variable x0 … i_x[7] is x7.
- o_y_dnf  output  5  function value from the DNF path, registered.
- o_y_cnf  output  5  function value from the CNF path, registered.
- o_error  output  1  registered flag; 1 when the DNF and CNF results differ.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, o_y_dnf=0, o_y_cnf=0, o_error=0, regardless of clk. Release is synchronous to the next rising edge; the first valid sample is taken on that edge.
- Function: F(x) = x[7:4] + x[3:0].
  - Both operands are unsigned 4-bit; the result is unsigned 5-bit, range 0..30.
  - No truncation or overflow is possible.
  - Output bit 4 is the MSB.
- DNF path: each output bit j is the OR of the full 8-literal minterms for every x where F(x)[j]=1. No adders, no logic minimisation in RTL source; synthesis may optimise.
- CNF path: each output bit j is the AND of the full 8-literal maxterms for every x where F(x)[j]=0.
- Both paths are purely combinational from i_x and are registered on the same rising edge.
- Latency: exactly 1 cycle. i_x sampled at edge n appears on o_y_dnf and o_y_cnf after edge n, with no throughput restriction. A new input is accepted every cycle.
- o_error is registered in the same cycle as the data: (dnf_comb != cnf_comb). It is never set for a correct implementation.
- o_error is not sticky; it clears on the next matching cycle.
- i_x changing between edges has no effect on outputs until the next edge; X on i_x must not corrupt registers already holding valid data.
- Reset asserted mid-stream: outputs clear immediately (asynchronous), and the in-flight sample is discarded.

Decomposition:
- Shared package tt_8_5_pkg:
  - constants N_IN=8 and N_OUT=5;
  - a constant-function or localparam table TT[0:255] of 5-bit values (F(x)) used to generate the minterm/maxterm lists and the bench model.
- One natural sub-module, tt_8_5_forms: purely combinational, input x[7:0], outputs y_dnf[4:0] and y_cnf[4:0].
- The top level instantiates tt_8_5_forms once and adds the output registers and the compare logic.

Test Plan:
- Reset held low with i_x=8'hFF and clk toggling -> all outputs 0 and o_error=0; asynchronous clear checked mid-cycle.
- i_x=8'h00 -> one cycle later o_y_dnf=o_y_cnf=5'b00000, o_error=0.
- i_x=8'hFF -> o_y_dnf=o_y_cnf=5'b11110 (30); i_x=8'h0F -> 5'b01111 (15).
- i_x=8'h81 -> 5'b01001 (9); i_x=8'h12 -> 5'b00011 (3), presented on back-to-back cycles to confirm 1-cycle latency and full throughput.
- Exhaustive sweep of i_x from 0 to 255, one value per clock -> every output matches TT[x] on both paths and o_error stays 0 for all 256 vectors.
- rst_n pulsed low during the sweep at i_x=8'h80 -> outputs zero immediately; after release, i_x=8'h80 -> 5'b01000 (8) on the next edge.
